// File: rtl/wave_meter.sv
// Waveform measurement receiver: averages the input period over 2^AVG_LOG2 rising
// crossings (with hysteresis) and captures peak-to-peak amplitude in the same window.
module wave_meter #(
  parameter int unsigned MID      = 128,
  parameter int unsigned HYST     = 8,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned PER_W    = 32,
  parameter int unsigned TIMEOUT  = 1_000_000
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             smp_en,
  input  logic [7:0]       smp,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [PER_W-1:0] period,
  output logic [7:0]       vmax,
  output logic [7:0]       vmin,
  output logic [7:0]       vpp
);

  localparam int unsigned NCROSS  = 1 << AVG_LOG2;
  localparam int unsigned WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [8:0]  THR_HI  = 9'(MID + HYST);
  localparam logic [8:0]  THR_LO  = 9'(MID - HYST);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [4:0]  NC_LAST = 5'(NCROSS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_SYNC,
    S_MEAS
  } state_t;

  state_t state_q, state_d;

  logic             lvl_q, lvl_d;
  logic [PER_W-1:0] acc_q, acc_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [4:0]       nc_q, nc_d;
  logic [7:0]       trk_max_q, trk_max_d;
  logic [7:0]       trk_min_q, trk_min_d;
  logic             done_q, done_d;
  logic             tmo_q, tmo_d;
  logic [PER_W-1:0] period_q, period_d;
  logic [7:0]       vmax_q, vmax_d;
  logic [7:0]       vmin_q, vmin_d;
  logic [7:0]       vpp_q, vpp_d;

  logic             active;
  logic             accept;
  logic             rise_ev;
  logic             fall_ev;
  logic             complete;
  logic             wd_exp;
  logic [PER_W-1:0] acc_inc;
  logic [7:0]       fin_max;
  logic [7:0]       fin_min;

  assign active   = (state_q != S_IDLE);
  assign accept   = (state_q == S_IDLE) && start;
  assign rise_ev  = active && smp_en && !lvl_q && ({1'b0, smp} >= THR_HI);
  assign fall_ev  = active && smp_en &&  lvl_q && ({1'b0, smp} <= THR_LO);
  assign complete = (state_q == S_MEAS) && rise_ev && (nc_q == NC_LAST);
  // Any crossing clears the watchdog, so a completing crossing always beats expiry.
  assign wd_exp   = active && !rise_ev && !fall_ev && (wd_q >= WD_LAST);
  assign acc_inc  = (acc_q == '1) ? acc_q : acc_q + PER_W'(1);
  assign fin_max  = (smp > trk_max_q) ? smp : trk_max_q;
  assign fin_min  = (smp < trk_min_q) ? smp : trk_min_q;

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_ARM;
      S_ARM: begin
        if (wd_exp)       state_d = S_IDLE;
        else if (fall_ev) state_d = S_SYNC;
      end
      S_SYNC: begin
        if (wd_exp)       state_d = S_IDLE;
        else if (rise_ev) state_d = S_MEAS;
      end
      S_MEAS: begin
        if (complete || wd_exp) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = active;
    done    = done_q;
    timeout = tmo_q;
    period  = period_q;
    vmax    = vmax_q;
    vmin    = vmin_q;
    vpp     = vpp_q;
  end

  always_comb begin
    lvl_d     = lvl_q;
    acc_d     = acc_q;
    wd_d      = wd_q;
    nc_d      = nc_q;
    trk_max_d = trk_max_q;
    trk_min_d = trk_min_q;
    done_d    = 1'b0;
    tmo_d     = tmo_q;
    period_d  = period_q;
    vmax_d    = vmax_q;
    vmin_d    = vmin_q;
    vpp_d     = vpp_q;

    // Forcing lvl high on arm means the first counted edge must follow a true low.
    if (accept) begin
      lvl_d = 1'b1;
      tmo_d = 1'b0;
    end else if (rise_ev) begin
      lvl_d = 1'b1;
    end else if (fall_ev) begin
      lvl_d = 1'b0;
    end

    if (accept || rise_ev || fall_ev || (state_d != state_q)) begin
      wd_d = '0;
    end else if (active) begin
      wd_d = wd_q + WD_W'(1);
    end

    case (state_q)
      S_SYNC: begin
        if (rise_ev) begin
          acc_d     = '0;
          nc_d      = '0;
          trk_max_d = smp;
          trk_min_d = smp;
        end
      end
      S_MEAS: begin
        acc_d = acc_inc;
        if (smp_en) begin
          trk_max_d = fin_max;
          trk_min_d = fin_min;
        end
        if (rise_ev) nc_d = nc_q + 5'd1;
      end
      default: ;
    endcase

    if (complete) begin
      done_d   = 1'b1;
      tmo_d    = 1'b0;
      period_d = acc_inc >> AVG_LOG2;
      vmax_d   = fin_max;
      vmin_d   = fin_min;
      vpp_d    = fin_max - fin_min;
    end else if (wd_exp) begin
      done_d = 1'b1;
      tmo_d  = 1'b1;
    end
  end

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      lvl_q     <= 1'b0;
      acc_q     <= '0;
      wd_q      <= '0;
      nc_q      <= '0;
      trk_max_q <= '0;
      trk_min_q <= '0;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
      period_q  <= '0;
      vmax_q    <= '0;
      vmin_q    <= '0;
      vpp_q     <= '0;
    end else begin
      lvl_q     <= lvl_d;
      acc_q     <= acc_d;
      wd_q      <= wd_d;
      nc_q      <= nc_d;
      trk_max_q <= trk_max_d;
      trk_min_q <= trk_min_d;
      done_q    <= done_d;
      tmo_q     <= tmo_d;
      period_q  <= period_d;
      vmax_q    <= vmax_d;
      vmin_q    <= vmin_d;
      vpp_q     <= vpp_d;
    end
  end

endmodule

// File: tb/tb_wave_meter.sv
// Bench for wave_meter: table of waveform cases, hand-built corner sequences, and
// randomized waveforms checked against a crossing-list reference model.
module tb_wave_meter;

  localparam int MID   = 128;
  localparam int HYST  = 8;
  localparam int TO    = 1000;
  localparam int N_MAX = 1600;
  localparam int THI   = MID + HYST;
  localparam int TLO   = MID - HYST;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        smp_en;
  logic [7:0]  smp;
  logic        start0, start1;
  logic        busy0, done0, tmo0, busy1, done1, tmo1;
  logic [31:0] per0, per1;
  logic [7:0]  vmax0, vmin0, vpp0, vmax1, vmin1, vpp1;

  always #5 clk = ~clk;

  wave_meter #(.MID(128), .HYST(8), .AVG_LOG2(2), .PER_W(32), .TIMEOUT(TO)) u_dut0 (
    .clkin(clk), .rst_n(rst_n), .smp_en(smp_en), .smp(smp), .start(start0),
    .busy(busy0), .done(done0), .timeout(tmo0), .period(per0),
    .vmax(vmax0), .vmin(vmin0), .vpp(vpp0));

  wave_meter #(.MID(128), .HYST(8), .AVG_LOG2(0), .PER_W(32), .TIMEOUT(TO)) u_dut1 (
    .clkin(clk), .rst_n(rst_n), .smp_en(smp_en), .smp(smp), .start(start1),
    .busy(busy1), .done(done1), .timeout(tmo1), .period(per1),
    .vmax(vmax1), .vmin(vmin1), .vpp(vpp1));

  int n_chk = 0;
  int n_err = 0;

  bit         en_a[N_MAX];
  bit         st_a[N_MAX];
  logic [7:0] sm_a[N_MAX];
  int         n_len;
  int         ex_per[2], ex_mx[2], ex_mn[2];

  typedef struct {
    int dut; int s; int p; int lo; int hi; int noise; bit sq;
    int e_idx; bit e_tmo; int e_per; int e_mx; int e_mn;
  } vec_t;
  vec_t tbl[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input int w);
    chk($sformatf("d%0d_rst_busy", w),    w ? busy1 : busy0, 0);
    chk($sformatf("d%0d_rst_done", w),    w ? done1 : done0, 0);
    chk($sformatf("d%0d_rst_timeout", w), w ? tmo1 : tmo0, 0);
    chk($sformatf("d%0d_rst_period", w),  w ? per1 : per0, 0);
    chk($sformatf("d%0d_rst_vmax", w),    w ? vmax1 : vmax0, 0);
    chk($sformatf("d%0d_rst_vmin", w),    w ? vmin1 : vmin0, 0);
    chk($sformatf("d%0d_rst_vpp", w),     w ? vpp1 : vpp0, 0);
  endtask

  // Waveform trace: triangle or square of p samples per period, one sample every s cycles.
  task automatic gen(input int s, input int p, input int lo, input int hi, input int noise,
                     input bit sq, input bit rnd, input int k0, input int len);
    int k, ph, half, v, nz;
    n_len = len;
    half  = p / 2;
    for (int i = 0; i < len; i++) begin
      st_a[i] = 1'b0;
      if (i % s == 0) begin
        k  = i / s + k0;
        ph = k % p;
        if (sq) v = (ph < half) ? hi : lo;
        else    v = (ph <= half) ? lo + (hi - lo) * ph / half : lo + (hi - lo) * (p - ph) / half;
        if (rnd) nz = int'($urandom_range(0, 2 * noise)) - noise;
        else     nz = (k % 2 == 0) ? noise : -noise;
        v = v + nz;
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        sm_a[i] = 8'(v);
        en_a[i] = rnd ? ($urandom_range(0, 7) != 0) : 1'b1;
      end else begin
        sm_a[i] = sm_a[i-1];
        en_a[i] = 1'b0;
      end
    end
  endtask

  // Reference: walk the strobed samples as a list of hysteresis crossings; the measured
  // window spans the first rising crossing after a low to the 2^k-th rising after it.
  function automatic void ref_run(input int k, output int idx, output bit tmo,
                                  output int per, output int mx, output int mn);
    bit lvl, rise, fall;
    int phase, f, seen, last, need;
    lvl = 1'b1; phase = 0; f = 0; seen = 0; last = 0; need = 1 << k;
    idx = -1; tmo = 1'b0; per = 0; mx = 0; mn = 0;
    for (int i = 0; i < n_len; i++) begin
      rise = en_a[i] && !lvl && (int'(sm_a[i]) >= THI);
      fall = en_a[i] &&  lvl && (int'(sm_a[i]) <= TLO);
      if (phase == 2 && en_a[i]) begin
        if (int'(sm_a[i]) > mx) mx = int'(sm_a[i]);
        if (int'(sm_a[i]) < mn) mn = int'(sm_a[i]);
      end
      if (rise) begin
        lvl = 1'b1;
        if (phase == 1) begin
          phase = 2; f = i; mx = int'(sm_a[i]); mn = int'(sm_a[i]);
        end else if (phase == 2) begin
          seen++;
          if (seen == need) begin
            idx = i; per = (i - f) >> k;
            return;
          end
        end
      end else if (fall) begin
        lvl = 1'b0;
        if (phase == 0) phase = 1;
      end
      if (rise || fall) last = i + 1;
      else if (i - last == TO - 1) begin
        idx = i; tmo = 1'b1;
        return;
      end
    end
  endfunction

  // Plays the trace; returns the trace index after which done was seen (-1 if never).
  task automatic play(input bit go0, input bit go1, input bit skip_start,
                      output int d0, output int d1);
    int early0, early1;
    early0 = 0; early1 = 0; d0 = -1; d1 = -1;
    if (!skip_start) begin
      start0 = go0; start1 = go1; smp_en = 1'b0;
      tick();
      start0 = 1'b0; start1 = 1'b0;
      if (go0) chk("d0_busy_rise", busy0, 1);
      if (go1) chk("d1_busy_rise", busy1, 1);
    end
    for (int i = 0; i < n_len; i++) begin
      smp_en = en_a[i];
      smp    = sm_a[i];
      start0 = go0 && st_a[i] && (d0 < 0);
      start1 = go1 && st_a[i] && (d1 < 0);
      tick();
      if (go0 && d0 < 0) begin
        if (done0) begin d0 = i; chk("d0_busy_at_done", busy0, 0); end
        else if (!busy0) early0++;
      end
      if (go1 && d1 < 0) begin
        if (done1) begin d1 = i; chk("d1_busy_at_done", busy1, 0); end
        else if (!busy1) early1++;
      end
      if ((!go0 || d0 >= 0) && (!go1 || d1 >= 0)) break;
    end
    start0 = 1'b0; start1 = 1'b0; smp_en = 1'b0;
    if (go0) chk("d0_busy_held", early0, 0);
    if (go1) chk("d1_busy_held", early1, 0);
  endtask

  task automatic judge(input int w, input int d, input int e_idx, input bit e_tmo,
                       input int e_per, input int e_mx, input int e_mn);
    chk($sformatf("d%0d_done_cycle", w), d, e_idx);
    if (e_idx >= 0) chk($sformatf("d%0d_timeout", w), w ? tmo1 : tmo0, e_tmo);
    if (e_idx >= 0 && !e_tmo) begin
      ex_per[w] = e_per; ex_mx[w] = e_mx; ex_mn[w] = e_mn;
    end
    chk($sformatf("d%0d_period", w), w ? per1 : per0, ex_per[w]);
    chk($sformatf("d%0d_vmax", w),   w ? vmax1 : vmax0, ex_mx[w]);
    chk($sformatf("d%0d_vmin", w),   w ? vmin1 : vmin0, ex_mn[w]);
    chk($sformatf("d%0d_vpp", w),    w ? vpp1 : vpp0, ex_mx[w] - ex_mn[w]);
  endtask

  task automatic post(input bit restart);
    start0 = restart;
    tick();
    start0 = 1'b0;
    chk("d0_done_one_cycle", done0, 0);
    chk("d0_busy_after_done", busy0, restart);
  endtask

  task automatic clear_exp();
    for (int w = 0; w < 2; w++) begin
      ex_per[w] = 0; ex_mx[w] = 0; ex_mn[w] = 0;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int d0, d1, e0, e1, p0, p1, m0, m1, n0, n1;
    bit t0, t1;
    int s, p, lo, hi;

    tbl[0] = '{0, 4, 20,  28, 228, 0, 1'b0, 344, 1'b0, 80, 228, 28};
    tbl[1] = '{0, 4, 20, 128, 128, 0, 1'b0, 999, 1'b1, 80, 228, 28};
    tbl[2] = '{0, 4, 20,  28, 228, 5, 1'b0, 344, 1'b0, 80, 233, 33};
    tbl[3] = '{0, 2,  6,  60, 180, 0, 1'b1,  60, 1'b0, 12, 180, 60};
    tbl[4] = '{1, 1,  8,  50, 200, 0, 1'b1,  16, 1'b0,  8, 200, 50};

    rst_n = 1'b0; smp_en = 1'b0; smp = '0; start0 = 1'b0; start1 = 1'b0;
    clear_exp();
    repeat (3) tick();
    chk_zero(0);
    chk_zero(1);
    rst_n = 1'b1;
    tick();

    foreach (tbl[j]) begin
      gen(tbl[j].s, tbl[j].p, tbl[j].lo, tbl[j].hi, tbl[j].noise, tbl[j].sq, 1'b0, 0, 1100);
      play(tbl[j].dut == 0, tbl[j].dut == 1, 1'b0, d0, d1);
      judge(tbl[j].dut, (tbl[j].dut == 1) ? d1 : d0, tbl[j].e_idx, tbl[j].e_tmo,
            tbl[j].e_per, tbl[j].e_mx, tbl[j].e_mn);
      tick();
    end

    // Single-cycle pulses: crossing gaps 7,8,7,8 -> acc+1=30 truncates to 7; single gap 7.
    n_len = 60;
    for (int i = 0; i < 60; i++) begin
      en_a[i] = 1'b1; st_a[i] = 1'b0; sm_a[i] = 8'd50;
    end
    sm_a[5] = 8'd200; sm_a[12] = 8'd200; sm_a[20] = 8'd200; sm_a[27] = 8'd200; sm_a[35] = 8'd200;
    play(1'b1, 1'b1, 1'b0, d0, d1);
    judge(0, d0, 35, 1'b0, 7, 200, 50);
    judge(1, d1, 12, 1'b0, 7, 200, 50);
    tick();

    // Starts while busy and in the completing cycle are ignored; start right after done is taken.
    gen(4, 20, 28, 228, 0, 1'b0, 1'b0, 0, 1100);
    st_a[10] = 1'b1; st_a[100] = 1'b1; st_a[344] = 1'b1;
    play(1'b1, 1'b0, 1'b0, d0, d1);
    judge(0, d0, 344, 1'b0, 80, 228, 28);
    post(1'b0);
    st_a[10] = 1'b0; st_a[100] = 1'b0; st_a[344] = 1'b0;
    play(1'b1, 1'b0, 1'b0, d0, d1);
    judge(0, d0, 344, 1'b0, 80, 228, 28);
    post(1'b1);
    play(1'b1, 1'b0, 1'b1, d0, d1);
    judge(0, d0, 344, 1'b0, 80, 228, 28);
    tick();

    // Reset mid-measurement, with start held during reset.
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      smp_en = en_a[i]; smp = sm_a[i];
      tick();
    end
    chk("d0_busy_before_rst", busy0, 1);
    rst_n = 1'b0; start0 = 1'b1; start1 = 1'b1;
    tick();
    chk_zero(0);
    chk_zero(1);
    clear_exp();
    rst_n = 1'b1; start0 = 1'b0; start1 = 1'b0; smp_en = 1'b0;
    tick();
    chk("d0_busy_after_rst", busy0, 0);
    chk("d1_busy_after_rst", busy1, 0);
    play(1'b1, 1'b0, 1'b0, d0, d1);
    judge(0, d0, 344, 1'b0, 80, 228, 28);
    tick();

    for (int r = 0; r < 16; r++) begin
      s = $urandom_range(1, 4);
      p = 2 * $urandom_range(3, 12);
      if ($urandom_range(0, 4) == 0) begin
        lo = $urandom_range(115, 127); hi = $urandom_range(128, 140);
      end else begin
        lo = $urandom_range(0, 110); hi = $urandom_range(146, 255);
      end
      gen(s, p, lo, hi, $urandom_range(0, 7), 1'($urandom_range(0, 1)), 1'b1,
          $urandom_range(0, p - 1), 1500);
      ref_run(2, e0, t0, p0, m0, n0);
      ref_run(0, e1, t1, p1, m1, n1);
      play(1'b1, 1'b1, 1'b0, d0, d1);
      judge(0, d0, e0, t0, p0, m0, n0);
      judge(1, d1, e1, t1, p1, m1, n1);
      if (e0 < 0 || e1 < 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        clear_exp();
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/wave_meter.md
# wave_meter

Waveform measurement receiver for the DDS signal path. It consumes the 8-bit unsigned sample stream returned from the ADC loopback, next to the DDS sine output and its DAC. On request it measures the average signal period in clkin cycles over 2^AVG_LOG2 cycles of the input, along with the peak-to-peak amplitude, then reports both with a one-cycle done pulse.

## Interface
- MID, 128: midscale threshold for crossing detection (unsigned 8-bit).
- HYST, 8: hysteresis half-width. The upper threshold is MID+HYST and the lower is MID−HYST. Legal range is 1..MID−1.
- AVG_LOG2, 2: number of input periods averaged is 2^AVG_LOG2. Legal range is 0..4.
- PER_W, 32: width of the period accumulator and output.
- TIMEOUT, 1_000_000: maximum clkin cycles allowed between accepted crossings, or between start and the first crossing.

- clkin  in  1  system clock; every register is on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- smp_en  in  1  sample strobe; smp is valid when this is 1.
- smp  in  8  unsigned sample.
- start  in  1  single-cycle measurement request.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when a result or timeout is posted.
- timeout  out  1  the last measurement aborted; held until the next accepted start.
- period  out  PER_W  average period in clkin cycles, equal to acc >> AVG_LOG2 (truncated).
- vmax  out  8  maximum sample inside the measurement window.
- vmin  out  8  minimum sample inside the measurement window.
- vpp  out  8  vmax − vmin.

## Operation
- Level tracker (hysteresis): a 1-bit lvl register.
  - When lvl=0 and smp_en and smp ≥ MID+HYST: rising crossing event, lvl←1.
  - When lvl=1 and smp_en and smp ≤ MID−HYST: lvl←0.
  - The tracker runs only outside IDLE. It is forced to lvl=1 on entry to ARM, so the input must first fall below the lower threshold. This guarantees the first counted edge is a true rising crossing.
- States:
  - IDLE: waits for start. Accepts start only in this state; start while busy is ignored. On an accepted start: timeout←0, lvl←1, go to ARM.
  - ARM: waits for a falling event (lvl 1→0), then goes to SYNC.
  - SYNC: on a rising event: acc←0, ncross←0, vmax←smp, vmin←smp, go to MEAS.
  - MEAS:
    - acc increments every cycle, saturating at all-ones.
    - On each smp_en cycle, vmax and vmin are updated with smp.
    - On each rising event, ncross increments. When ncross reaches 2^AVG_LOG2 (the event that completes the count), the result is posted and the state returns to IDLE.
- Timeout: a watchdog wd is cleared on start, on every rising and falling event, and on entry to each state. It increments in ARM, SYNC and MEAS.
  - When wd reaches TIMEOUT: timeout←1, done pulses, return to IDLE.
  - period, vmax, vmin and vpp keep their previous values on timeout.
- Result post: period←(acc+1) >> AVG_LOG2, vpp←vmax−vmin (both include the final sample).
  - Results hold until the next successful post.
  - acc+1 is the distance in cycles between the first and last crossing sample cycles.
- Reset (rst_n=0 on any cycle, including mid-measurement): state←IDLE, lvl←0, acc←0, wd←0, ncross←0. All outputs are 0: busy, done, timeout, period, vmax, vmin, vpp.

## Timing
- An accepted start at cycle t gives busy=1 from t+1.
- A completing rising event (smp_en sampled) at cycle c gives done=1, busy=0, and new outputs, all at c+1. done lasts exactly one cycle.
- An event is evaluated in the cycle smp_en is high. No internal input pipeline; smp must be stable on smp_en cycles.
- If a sample crosses both thresholds across consecutive strobes, only one transition per strobe is taken.
- start in the same cycle as the done post is ignored (the state is not yet IDLE). start at c+1 is accepted.
- start while rst_n=0 is ignored.
- acc saturates and does not wrap. A saturated result is reported as all-ones >> AVG_LOG2.
- If timeout and a completing crossing occur in the same cycle, the completing crossing wins: a result is posted and timeout=0.

## Test plan
- Triangle source with smp_en every 4 cycles, 20 samples per period, swinging 28..228, AVG_LOG2=2 → done with period=80, vmax=228, vmin=28, vpp=200, timeout=0.
- Constant smp=128 with TIMEOUT=1000 → done exactly 1000 cycles after busy rises, timeout=1, period/vpp unchanged from the previous run.
- Noise of ±5 around MID (within HYST) superimposed on a valid sine → no extra crossings, period identical to the clean run.
- start pulses while busy, and in the done cycle → ignored (single done, busy unchanged); start one cycle after done → new measurement begins.
- rst_n low for one cycle mid-MEAS → next cycle all outputs 0 and state IDLE; a subsequent start measures correctly.
- AVG_LOG2=0 with a period of 7 cycles (period not a multiple of the strobe spacing) → period=7; with AVG_LOG2=2 and acc+1=30 → period=7 (truncation).
